// File: rtl/issue_sequencer.sv
// In-order issue controller: buffers decoded requests, tags each with a free
// instruction ID and dispatches to the target VFU once hazard-free and ready.
package issue_sequencer_pkg;
    localparam int NrVFU     = 4;
    localparam int InsnIDNum = 4;

    typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;

    typedef struct packed {
        insn_id_t   insn_id;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [2:0] use_vs;
        logic [3:0] op;
    } issue_req_t;
endpackage

module issue_sequencer
    import issue_sequencer_pkg::*;
#(
    parameter int Depth   = 2,
    parameter int VfuIdxW = $clog2(NrVFU)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  issue_req_t                       req_i,
    input  logic [VfuIdxW-1:0]               req_vfu_i,
    output issue_req_t                       sb_req_o,
    input  logic                             sb_stall_i,
    output logic                             sb_issued_o,
    output logic [NrVFU-1:0]                 vfu_valid_o,
    input  logic [NrVFU-1:0]                 vfu_ready_i,
    output issue_req_t                       vfu_req_o,
    input  logic [NrVFU-1:0]                 insn_done_i,
    input  insn_id_t [NrVFU-1:0]             insn_done_id_i,
    output logic [$clog2(InsnIDNum):0]       inflight_o,
    output logic                             idle_o
);

    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW  = $clog2(Depth + 1);
    localparam int InflW = $clog2(InsnIDNum) + 1;

    issue_req_t          mem_req [Depth];
    logic [VfuIdxW-1:0]  mem_vfu [Depth];
    logic [PtrW-1:0]     wr_ptr_reg;
    logic [PtrW-1:0]     rd_ptr_reg;
    logic [CntW-1:0]     count_reg;
    logic [InsnIDNum-1:0] free_reg;
    logic [InsnIDNum-1:0] free_next;
    logic [InflW-1:0]    inflight_reg;
    logic [InflW-1:0]    free_cnt;

    logic                enq;
    logic                fire;
    logic                head_valid;
    logic                id_avail;
    logic                can_go;
    insn_id_t            alloc_id;
    issue_req_t          head_req;
    logic [VfuIdxW-1:0]  head_vfu;
    issue_req_t          sb_req;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_ready_o = count_reg < CntW'(Depth);
    assign enq         = req_valid_i && req_ready_o;
    assign head_valid  = count_reg != '0;
    assign head_req    = mem_req[rd_ptr_reg];
    assign head_vfu    = mem_vfu[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_req[wr_ptr_reg] <= req_i;
            mem_vfu[wr_ptr_reg] <= req_vfu_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (fire) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (enq && !fire) begin
                count_reg <= count_reg + 1'b1;
            end else if (!enq && fire) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Lowest free ID wins; only the registered bitmap is consulted so a
    // same-cycle release never feeds the allocator.
    always_comb begin
        alloc_id = '0;
        for (int i = InsnIDNum - 1; i >= 0; i--) begin
            if (free_reg[i]) begin
                alloc_id = insn_id_t'(i);
            end
        end
    end

    assign id_avail = |free_reg;

    always_comb begin
        sb_req         = head_req;
        sb_req.insn_id = alloc_id;
        if (!head_valid) begin
            sb_req.use_vs = '0;
        end
    end

    assign sb_req_o  = sb_req;
    assign vfu_req_o = sb_req;

    // Valid is independent of vfu_ready_i to keep the handshake loop-free.
    assign can_go = head_valid && !sb_stall_i && id_avail;

    for (genvar gi = 0; gi < NrVFU; gi++) begin : g_valid
        assign vfu_valid_o[gi] = can_go && (head_vfu == VfuIdxW'(gi));
    end

    assign fire        = |(vfu_valid_o & vfu_ready_i);
    assign sb_issued_o = fire;

    always_comb begin
        free_next = free_reg;
        if (fire) begin
            free_next[alloc_id] = 1'b0;
        end
        for (int k = 0; k < NrVFU; k++) begin
            if (insn_done_i[k]) begin
                free_next[insn_done_id_i[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < InsnIDNum; i++) begin
            free_cnt = free_cnt + InflW'(free_next[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_reg     <= '1;
            inflight_reg <= '0;
        end else begin
            free_reg     <= free_next;
            inflight_reg <= InflW'(InsnIDNum) - free_cnt;
        end
    end

    assign inflight_o = inflight_reg;
    assign idle_o     = !head_valid && (inflight_reg == '0);

    // Releasing an ID that is already free means a VFU reported a bogus completion.
    for (genvar gi = 0; gi < NrVFU; gi++) begin : g_rel_chk
        assert property (@(posedge clk_i) disable iff (rst_i)
            insn_done_i[gi] |-> !free_reg[insn_done_id_i[gi]]);
    end

endmodule

// File: tb/tb_issue_sequencer.sv
// Directed, table-driven bench for issue_sequencer (Depth=2, 4 VFUs, 4 IDs).
module tb_issue_sequencer;
    import issue_sequencer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 req_valid_i;
    logic                 req_ready_o;
    issue_req_t           req_i;
    logic [1:0]           req_vfu_i;
    issue_req_t           sb_req_o;
    logic                 sb_stall_i;
    logic                 sb_issued_o;
    logic [3:0]           vfu_valid_o;
    logic [3:0]           vfu_ready_i;
    issue_req_t           vfu_req_o;
    logic [3:0]           insn_done_i;
    insn_id_t [3:0]       insn_done_id_i;
    logic [2:0]           inflight_o;
    logic                 idle_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] vfu;
        logic [4:0] vd;
        logic       stall;
        logic [3:0] rdy;
        logic [3:0] done;
        logic [7:0] dids;
        logic       e_ready;
        logic [3:0] e_valid;
        logic       e_issued;
        logic       cid;
        logic [1:0] e_id;
        logic [2:0] e_infl;
        logic       e_idle;
        logic       e_head;
        logic [4:0] e_vd;
    } vec_t;

    vec_t tbl [23];
    vec_t h;

    issue_sequencer #(.Depth(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_i          (req_i),
        .req_vfu_i      (req_vfu_i),
        .sb_req_o       (sb_req_o),
        .sb_stall_i     (sb_stall_i),
        .sb_issued_o    (sb_issued_o),
        .vfu_valid_o    (vfu_valid_o),
        .vfu_ready_i    (vfu_ready_i),
        .vfu_req_o      (vfu_req_o),
        .insn_done_i    (insn_done_i),
        .insn_done_id_i (insn_done_id_i),
        .inflight_o     (inflight_o),
        .idle_o         (idle_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL step%0d %s: got %0d expected %0d", idx, nm, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input int idx);
        rst_i          = t.rst;
        req_valid_i    = t.v;
        req_vfu_i      = t.vfu;
        req_i.insn_id  = 2'd3;
        req_i.vd       = t.vd;
        req_i.vs1      = 5'd1;
        req_i.vs2      = 5'd2;
        req_i.use_vs   = 3'b111;
        req_i.op       = 4'h5;
        sb_stall_i     = t.stall;
        vfu_ready_i    = t.rdy;
        insn_done_i    = t.done;
        insn_done_id_i = t.dids;
        @(negedge clk);
        if (!t.rst) begin
            chk("ready",    idx, int'(req_ready_o), int'(t.e_ready));
            chk("valid",    idx, int'(vfu_valid_o), int'(t.e_valid));
            chk("issued",   idx, int'(sb_issued_o), int'(t.e_issued));
            chk("inflight", idx, int'(inflight_o),  int'(t.e_infl));
            chk("idle",     idx, int'(idle_o),      int'(t.e_idle));
            chk("use_vs",   idx, int'(sb_req_o.use_vs), t.e_head ? 7 : 0);
            if (t.cid) begin
                chk("id", idx, int'(sb_req_o.insn_id), int'(t.e_id));
            end
            if (t.e_valid != 4'd0) begin
                chk("vd",      idx, int'(sb_req_o.vd),       int'(t.e_vd));
                chk("vfu_id",  idx, int'(vfu_req_o.insn_id), int'(t.e_id));
            end
            $display("step%0d ready=%0d valid=%b issued=%0d id=%0d inflight=%0d idle=%0d",
                     idx, req_ready_o, vfu_valid_o, sb_issued_o, sb_req_o.insn_id,
                     inflight_o, idle_o);
        end else begin
            $display("step%0d reset", idx);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst  v    vfu   vd     st   rdy    done   dids   | rdy  valid  iss  cid  id    infl  idle head vd
        tbl[0]  = '{1'b0,1'b1,2'd1,5'd3,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd0,3'd0,1'b1,1'b0,5'd0};
        tbl[1]  = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h2,1'b1,1'b1,2'd0,3'd0,1'b0,1'b1,5'd3};
        tbl[2]  = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd1,3'd1,1'b0,1'b0,5'd0};
        tbl[3]  = '{1'b0,1'b1,2'd2,5'd4,1'b1,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd1,3'd1,1'b0,1'b0,5'd0};
        for (int i = 4; i <= 8; i++) begin
            tbl[i] = '{1'b0,1'b0,2'd0,5'd0,1'b1,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd1,3'd1,1'b0,1'b1,5'd0};
        end
        tbl[9]  = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h4,1'b1,1'b1,2'd1,3'd1,1'b0,1'b1,5'd4};
        tbl[10] = '{1'b0,1'b1,2'd0,5'd5,1'b0,4'h0,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd2,3'd2,1'b0,1'b0,5'd0};
        tbl[11] = '{1'b0,1'b1,2'd3,5'd6,1'b0,4'h0,4'h0,8'h00, 1'b1,4'h1,1'b0,1'b1,2'd2,3'd2,1'b0,1'b1,5'd5};
        tbl[12] = '{1'b0,1'b1,2'd1,5'd7,1'b0,4'h0,4'h0,8'h00, 1'b0,4'h1,1'b0,1'b1,2'd2,3'd2,1'b0,1'b1,5'd5};
        tbl[13] = '{1'b0,1'b1,2'd1,5'd7,1'b0,4'hF,4'h0,8'h00, 1'b0,4'h1,1'b1,1'b1,2'd2,3'd2,1'b0,1'b1,5'd5};
        tbl[14] = '{1'b0,1'b1,2'd1,5'd7,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h8,1'b1,1'b1,2'd3,3'd3,1'b0,1'b1,5'd6};
        tbl[15] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b0,2'd0,3'd4,1'b0,1'b1,5'd0};
        tbl[16] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h4,8'h20, 1'b1,4'h0,1'b0,1'b0,2'd0,3'd4,1'b0,1'b1,5'd0};
        tbl[17] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h2,1'b1,1'b1,2'd2,3'd3,1'b0,1'b1,5'd7};
        tbl[18] = '{1'b0,1'b1,2'd2,5'd8,1'b0,4'hF,4'h1,8'h01, 1'b1,4'h0,1'b0,1'b0,2'd0,3'd4,1'b0,1'b0,5'd0};
        tbl[19] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h9,8'hC0, 1'b1,4'h4,1'b1,1'b1,2'd1,3'd3,1'b0,1'b1,5'd8};
        tbl[20] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd0,3'd2,1'b0,1'b0,5'd0};
        tbl[21] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h3,8'h09, 1'b1,4'h0,1'b0,1'b1,2'd0,3'd2,1'b0,1'b0,5'd0};
        tbl[22] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd0,3'd0,1'b1,1'b0,5'd0};

        rst_i          = 1'b1;
        req_valid_i    = 1'b0;
        req_vfu_i      = 2'd0;
        req_i          = '0;
        sb_stall_i     = 1'b0;
        vfu_ready_i    = 4'h0;
        insn_done_i    = 4'h0;
        insn_done_id_i = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            run(tbl[i], i);
        end

        // Fill: three IDs issued, two entries parked behind a busy VFU.
        h = '{1'b0,1'b1,2'd0,5'd9, 1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd0,3'd0,1'b1,1'b0,5'd0};  run(h, 100);
        h = '{1'b0,1'b1,2'd0,5'd10,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h1,1'b1,1'b1,2'd0,3'd0,1'b0,1'b1,5'd9};  run(h, 101);
        h = '{1'b0,1'b1,2'd0,5'd11,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h1,1'b1,1'b1,2'd1,3'd1,1'b0,1'b1,5'd10}; run(h, 102);
        h = '{1'b0,1'b0,2'd0,5'd0, 1'b0,4'hF,4'h0,8'h00, 1'b1,4'h1,1'b1,1'b1,2'd2,3'd2,1'b0,1'b1,5'd11}; run(h, 103);
        h = '{1'b0,1'b1,2'd0,5'd12,1'b0,4'h0,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd3,3'd3,1'b0,1'b0,5'd0};  run(h, 104);
        h = '{1'b0,1'b1,2'd0,5'd13,1'b0,4'h0,4'h0,8'h00, 1'b1,4'h1,1'b0,1'b1,2'd3,3'd3,1'b0,1'b1,5'd12}; run(h, 105);
        h = '{1'b0,1'b0,2'd0,5'd0, 1'b0,4'h0,4'h0,8'h00, 1'b0,4'h1,1'b0,1'b1,2'd3,3'd3,1'b0,1'b1,5'd12}; run(h, 106);
        // One-cycle reset with a request and a completion offered; both are dropped.
        h = '{1'b1,1'b1,2'd1,5'd20,1'b0,4'hF,4'h1,8'h00, 1'b1,4'h0,1'b0,1'b0,2'd0,3'd0,1'b1,1'b0,5'd0};  run(h, 107);
        h = '{1'b0,1'b0,2'd0,5'd0, 1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd0,3'd0,1'b1,1'b0,5'd0};  run(h, 108);
        h = '{1'b0,1'b1,2'd2,5'd14,1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd0,3'd0,1'b1,1'b0,5'd0};  run(h, 109);
        h = '{1'b0,1'b0,2'd0,5'd0, 1'b0,4'hF,4'h0,8'h00, 1'b1,4'h4,1'b1,1'b1,2'd0,3'd0,1'b0,1'b1,5'd14}; run(h, 110);
        h = '{1'b0,1'b0,2'd0,5'd0, 1'b0,4'hF,4'h0,8'h00, 1'b1,4'h0,1'b0,1'b1,2'd1,3'd1,1'b0,1'b0,5'd0};  run(h, 111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
